updown_blinker_multi: RTL

Parametrised multi-LED blinker with push-button rate control and pattern modes. Two debounced push buttons step the blink rate up/down through a saturating set of power-of-two rates; pressing both together cycles the LED pattern mode. Sits at top level between the board oscillator, the push buttons and the LED bank, replacing the fixed two-LED up/down blinker.

---
 rtl/blinker_pkg.sv | 21 ++
 rtl/pb_debounce.sv | 52 +++++
 rtl/updown_blinker_multi.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/blinker_pkg.sv
// Shared definitions for the push-button blinker: pattern mode encodings and a clog2 helper.
// Latency: n/a (types and constants only); backpressure: n/a.
package blinker_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'd0,
        MODE_ALT    = 2'd1,
        MODE_WALK   = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    function automatic int clog2(input longint value);
        int r;
        r = 0;
        while ((longint'(1) << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pb_debounce.sv
// One push button: 2-flop synchroniser followed by a consecutive-stable-cycles debouncer.
// Latency: 2 + DEBOUNCE_CYC cycles from raw edge to pb_db; backpressure: none.
module pb_debounce
    import blinker_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic OSC_FPGA,
    input  logic RST,
    input  logic pb_raw,
    output logic pb_db
);

    localparam int DW = (clog2(DEBOUNCE_CYC) < 1) ? 1 : clog2(DEBOUNCE_CYC);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    // Counter only runs while the synchronised level disagrees with db; any agreement clears it.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge OSC_FPGA) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pb_raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pb_db = db_q;

endmodule

// File: rtl/updown_blinker_multi.sv
// Multi-LED blinker: debounced up/down buttons step a power-of-two blink rate, chord cycles pattern mode.
// Latency: 1 cycle from debounced button change to RATE/MODE/LED reload; backpressure: none.
module updown_blinker_multi
    import blinker_pkg::*;
#(
    parameter  int N_LED        = 2,
    parameter  int BASE_DIV     = 25000000,
    parameter  int N_RATES      = 4,
    parameter  int RATE_INIT    = 1,
    parameter  int DEBOUNCE_CYC = 500000,
    localparam int RW           = (clog2(N_RATES) < 1) ? 1 : clog2(N_RATES)
) (
    input  logic             OSC_FPGA,
    input  logic             RST,
    input  logic [1:0]       PB,
    output logic [N_LED-1:0] LED,
    output logic [1:0]       MODE,
    output logic [RW-1:0]    RATE
);

    localparam int CW = clog2(BASE_DIV) + N_RATES - 1;

    logic [1:0]       db;
    logic [1:0]       db_q;
    logic [1:0]       db_d;
    logic [RW-1:0]    rate_q;
    logic [RW-1:0]    rate_d;
    mode_e            mode_q;
    mode_e            mode_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [N_LED-1:0] led_q;
    logic [N_LED-1:0] led_d;
    logic             dir_up_q;
    logic             dir_up_d;

    logic [CW:0]      hp;
    logic             tick;
    logic             chord;
    logic             up_ev;
    logic             dn_ev;
    logic [N_LED-1:0] step_led;
    logic             step_dir;
    logic             go_up;

    pb_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn (
        .OSC_FPGA (OSC_FPGA),
        .RST      (RST),
        .pb_raw   (PB[0]),
        .pb_db    (db[0])
    );

    pb_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
        .OSC_FPGA (OSC_FPGA),
        .RST      (RST),
        .pb_raw   (PB[1]),
        .pb_db    (db[1])
    );

    function automatic logic [N_LED-1:0] init_pattern(input mode_e m);
        logic [N_LED-1:0] p;
        p = '0;
        case (m)
            MODE_ALT: begin
                for (int i = 0; i < N_LED; i++) begin
                    if (i % 2 == 0) p[i] = 1'b1;
                end
            end
            MODE_WALK, MODE_BOUNCE: p[0] = 1'b1;
            default: p = '0;
        endcase
        return p;
    endfunction

    // One extra bit so BASE_DIV << (N_RATES-1) itself is representable; cnt only reaches HP-1.
    assign hp    = (CW + 1)'(BASE_DIV) << rate_q;
    assign tick  = ({1'b0, cnt_q} == (hp - (CW + 1)'(1)));
    assign chord = (db == 2'b11) && (db_q != 2'b11);
    assign up_ev = db[1] && !db_q[1] && !db[0];
    assign dn_ev = db[0] && !db_q[0] && !db[1];

    always_comb begin
        step_led = led_q;
        step_dir = dir_up_q;
        go_up    = 1'b0;
        case (mode_q)
            MODE_BLINK, MODE_ALT: step_led = ~led_q;
            MODE_WALK: begin
                for (int i = 0; i < N_LED; i++) begin
                    step_led[i] = led_q[(i + N_LED - 1) % N_LED];
                end
            end
            MODE_BOUNCE: begin
                // Reverse at an end on the same tick so the end LED is not shown twice.
                if (N_LED > 1) begin
                    go_up    = dir_up_q ? !led_q[N_LED-1] : led_q[0];
                    step_led = go_up ? (led_q << 1) : (led_q >> 1);
                    step_dir = go_up;
                end
            end
            default: step_led = led_q;
        endcase
    end

    always_comb begin
        db_d     = db;
        rate_d   = rate_q;
        mode_d   = mode_q;
        cnt_d    = tick ? '0 : cnt_q + CW'(1);
        led_d    = tick ? step_led : led_q;
        dir_up_d = tick ? step_dir : dir_up_q;
        if (chord) begin
            mode_d   = mode_e'(mode_q + 2'd1);
            cnt_d    = '0;
            led_d    = init_pattern(mode_d);
            dir_up_d = 1'b1;
        end else if (up_ev && (rate_q != '0)) begin
            rate_d   = rate_q - RW'(1);
            cnt_d    = '0;
            led_d    = led_q;
            dir_up_d = dir_up_q;
        end else if (dn_ev && (rate_q != RW'(N_RATES - 1))) begin
            rate_d   = rate_q + RW'(1);
            cnt_d    = '0;
            led_d    = led_q;
            dir_up_d = dir_up_q;
        end
    end

    always_ff @(posedge OSC_FPGA) begin
        if (RST) begin
            db_q     <= '0;
            rate_q   <= RW'(RATE_INIT);
            mode_q   <= MODE_BLINK;
            cnt_q    <= '0;
            led_q    <= '0;
            dir_up_q <= 1'b1;
        end else begin
            db_q     <= db_d;
            rate_q   <= rate_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            led_q    <= led_d;
            dir_up_q <= dir_up_d;
        end
    end

    assign LED  = led_q;
    assign MODE = mode_q;
    assign RATE = rate_q;

endmodule
